// File: rtl/riscv_imem_apb.sv
// APB3 read-only instruction memory feeding the fetch unit: programmable wait states,
// PSLVERR on writes/misaligned/out-of-range accesses, and a backdoor preload port.
module riscv_imem_apb #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic [31:0]              paddr_i,
    input  logic                     pwrite_i,
    input  logic [31:0]              pwdata_i,
    output logic                     pready_o,
    output logic [31:0]              prdata_o,
    output logic                     pslverr_o,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
    input  logic [31:0]              ld_data_i,
    output logic [31:0]              fetch_cnt_o,
    output logic [15:0]              err_cnt_o
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [3:0] WS          = 4'(WAIT_STATES);
    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_ACCESS = 1'b1;

    logic [31:0]   r_mem [DEPTH];
    logic [3:0]    r_wait_cnt;
    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [31:0]   r_fetch_cnt;
    logic [15:0]   r_err_cnt;

    logic          w_access;
    logic          w_ready;
    logic          w_err;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_unused_bits;

    assign w_access = psel_i & penable_i;
    // Gated with reset_n so an asserted reset kills PREADY in the same instant.
    assign w_ready  = reset_n & w_access & (r_wait_cnt == WS);

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign w_off = paddr_i - BASE_ADDR;
    assign w_idx = w_off[AW+1:2];
    assign w_err = pwrite_i | (paddr_i[1:0] != 2'b00) | (w_off[31:AW+2] != '0);

    assign w_unused_bits = ^{pwdata_i, w_off[1:0]};

    assign pready_o  = w_ready;
    assign pslverr_o = w_ready & w_err;
    assign prdata_o  = (w_ready && !w_err) ? r_mem[w_idx] : 32'h0;

    assign fetch_cnt_o = r_fetch_cnt;
    assign err_cnt_o   = r_err_cnt;

    always_comb begin
        w_state_next = r_state;
        if (w_ready || !psel_i) begin
            w_state_next = STATE_IDLE;
        end else if (w_access) begin
            w_state_next = STATE_ACCESS;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= STATE_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (w_ready || !psel_i) begin
                r_wait_cnt <= 4'd0;
            end else if (w_access && (r_wait_cnt < WS)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_cnt <= 32'h0;
            r_err_cnt   <= 16'h0;
        end else if (w_ready) begin
            if (w_err) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else begin
                if (r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    // Reads are combinational, so a load landing on the same edge returns the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_INSTR;
            end
        end else if (ld_en_i) begin
            r_mem[ld_idx_i] <= ld_data_i;
        end
    end

endmodule

// File: tb/tb_riscv_imem_apb.sv
// Bench for riscv_imem_apb: three instances with 0, 1 and 3 wait states, a vector table
// on the 1-wait-state instance and hand sequences for abort, collision and mid-transfer reset.
module tb_riscv_imem_apb;

    localparam int AW = 8;

    logic        clk;
    logic        reset_n;
    logic        psel    [3];
    logic        penable [3];
    logic [31:0] paddr   [3];
    logic        pwrite  [3];
    logic [31:0] pwdata  [3];
    logic        pready  [3];
    logic [31:0] prdata  [3];
    logic        pslverr [3];
    logic [31:0] fetch_cnt [3];
    logic [15:0] err_cnt   [3];
    logic          ld_en;
    logic [AW-1:0] ld_idx;
    logic [31:0]   ld_data;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: 0 wait states, 1: 1 wait state, 2: 3 wait states.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
        riscv_imem_apb #(
            .BASE_ADDR   (32'h8000_0000),
            .DEPTH       (256),
            .WAIT_STATES (WS),
            .RESET_INSTR (32'h0000_0013)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .psel_i      (psel[gi]),
            .penable_i   (penable[gi]),
            .paddr_i     (paddr[gi]),
            .pwrite_i    (pwrite[gi]),
            .pwdata_i    (pwdata[gi]),
            .pready_o    (pready[gi]),
            .prdata_o    (prdata[gi]),
            .pslverr_o   (pslverr[gi]),
            .ld_en_i     (ld_en),
            .ld_idx_i    (ld_idx),
            .ld_data_i   (ld_data),
            .fetch_cnt_o (fetch_cnt[gi]),
            .err_cnt_o   (err_cnt[gi])
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic load(input logic [AW-1:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One complete transfer on instance k; cyc = access cycle in which PREADY was seen.
    task automatic apb_xfer(input int k, input logic [31:0] addr, input logic wr,
                            output logic [31:0] rd, output logic err, output int cyc);
        @(negedge clk);
        psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = addr; pwrite[k] = wr;
        pwdata[k] = 32'hDEAD_BEEF;
        @(negedge clk);
        penable[k] = 1'b1;
        cyc = 0; rd = 32'h0; err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (pready[k]) begin
                cyc = c; rd = prdata[k]; err = pslverr[k];
                break;
            end
            chk($sformatf("idle_out%0d", k), {31'h0, pslverr[k]} | prdata[k], 32'h0);
            @(negedge clk);
        end
        if (cyc == 0) chk("ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          cyc;

    initial begin
        reset_n = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        for (int k = 0; k < 3; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; paddr[k] = '0; pwrite[k] = 1'b0; pwdata[k] = '0;
        end
        vecs[0] = '{32'h8000_0000, 1'b0, 1'b0, 32'h0000_0013};
        vecs[1] = '{32'h8000_000C, 1'b0, 1'b0, 32'h00A0_0093};
        vecs[2] = '{32'h8000_0002, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h8000_0400, 1'b0, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h7FFF_FFFC, 1'b0, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000};
        vecs[6] = '{32'h8000_03FC, 1'b0, 1'b0, 32'h0000_0013};
        vecs[7] = '{32'h8000_0004, 1'b0, 1'b0, 32'h0000_0013};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_pready",  {31'h0, pready[1]}, 32'h0);
        chk("rst_prdata",  prdata[1], 32'h0);
        chk("rst_pslverr", {31'h0, pslverr[1]}, 32'h0);
        chk("rst_fetch",   fetch_cnt[1], 32'h0);
        chk("rst_err",     {16'h0, err_cnt[1]}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single first read, then preload word 3 and run the table.
        apb_xfer(1, 32'h8000_0000, 1'b0, rd, err, cyc);
        chk("t1_data", rd, 32'h0000_0013);
        chk("t1_cyc", cyc, 32'd2);
        chk("t1_fetch", fetch_cnt[1], 32'd1);
        load(8'd3, 32'h00A0_0093);

        for (int v = 0; v < 8; v++) begin
            apb_xfer(1, vecs[v].addr, vecs[v].wr, rd, err, cyc);
            chk($sformatf("vec%0d_data", v), rd, vecs[v].exp_data);
            chk($sformatf("vec%0d_err", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
            chk($sformatf("vec%0d_cyc", v), cyc, 32'd2);
        end
        chk("tab_fetch", fetch_cnt[1], 32'd5);
        chk("tab_err", {16'h0, err_cnt[1]}, 32'd4);
        apb_xfer(1, 32'h8000_0000, 1'b0, rd, err, cyc);
        chk("after_write_data", rd, 32'h0000_0013);

        // Four back-to-back reads on the 0- and 3-wait-state instances.
        for (int k = 0; k < 3; k += 2) begin
            for (int r = 0; r < 4; r++) begin
                apb_xfer(k, 32'h8000_0000 + 32'(4 * r), 1'b0, rd, err, cyc);
                chk($sformatf("b2b%0d_%0d_cyc", k, r), cyc, (k == 0) ? 32'd1 : 32'd4);
                chk($sformatf("b2b%0d_%0d_data", k, r), rd, (r == 3) ? 32'h00A0_0093 : 32'h0000_0013);
            end
            chk($sformatf("b2b%0d_fetch", k), fetch_cnt[k], 32'd4);
        end

        // Abort after one access cycle on the 3-wait-state instance, then a fresh read.
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h8000_000C;
        @(negedge clk);
        penable[2] = 1'b1;
        #1 chk("abort_noready", {31'h0, pready[2]}, 32'h0);
        @(negedge clk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        apb_xfer(2, 32'h8000_000C, 1'b0, rd, err, cyc);
        chk("fresh_cyc", cyc, 32'd4);
        chk("fresh_data", rd, 32'h00A0_0093);
        chk("fresh_fetch", fetch_cnt[2], 32'd5);
        chk("fresh_err", {16'h0, err_cnt[2]}, 32'd0);

        // Backdoor load to the word being read in the PREADY cycle.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h8000_0014;
        @(negedge clk);
        penable[1] = 1'b1;
        #1 chk("coll_wait", {31'h0, pready[1]}, 32'h0);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 8'd5; ld_data = 32'h1234_5678;
        #1;
        chk("coll_ready", {31'h0, pready[1]}, 32'h1);
        chk("coll_old", prdata[1], 32'h0000_0013);
        @(posedge clk);
        #1;
        ld_en = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        apb_xfer(1, 32'h8000_0014, 1'b0, rd, err, cyc);
        chk("coll_new", rd, 32'h1234_5678);
        chk("coll_fetch", fetch_cnt[1], 32'd8);

        // Reset during a wait state (instance 2) and during a ready cycle (instance 0).
        @(negedge clk);
        psel[0] = 1'b1; paddr[0] = 32'h8000_0000;
        psel[2] = 1'b1; paddr[2] = 32'h8000_0000;
        @(negedge clk);
        penable[0] = 1'b1; penable[2] = 1'b1;
        #1;
        chk("pre_rst_ready0", {31'h0, pready[0]}, 32'h1);
        chk("pre_rst_wait2", {31'h0, pready[2]}, 32'h0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready0", {31'h0, pready[0]}, 32'h0);
        chk("rst_prdata0", prdata[0], 32'h0);
        chk("rst_fetch0", fetch_cnt[0], 32'h0);
        chk("rst_fetch2", fetch_cnt[2], 32'h0);
        chk("rst_fetch1", fetch_cnt[1], 32'h0);
        chk("rst_err1", {16'h0, err_cnt[1]}, 32'h0);
        psel[0] = 1'b0; penable[0] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        apb_xfer(1, 32'h8000_000C, 1'b0, rd, err, cyc);
        chk("post_rst_w3", rd, 32'h0000_0013);
        apb_xfer(1, 32'h8000_0014, 1'b0, rd, err, cyc);
        chk("post_rst_w5", rd, 32'h0000_0013);
        chk("post_rst_fetch", fetch_cnt[1], 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
